coalescing_store_buffer: RTL
============================

Name:
coalescing_store_buffer

Overview:
- Parametrised, multi-entry store buffer sitting between the data cache store-hit path and the cache/backing-memory write port.
- Next generation of the single-path store buffer, adding:
  - configurable depth and data width;
  - byte-granular write coalescing into existing entries;
  - multi-entry, youngest-wins store-to-load forwarding;
  - a valid/ready drain handshake.
- Entries drain in FIFO order.
- Loads in MEM probe the buffer combinationally every cycle.

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- ADDR_W, 32: byte-address width.
- DATA_W, 32: entry data width; multiple of 8. BE_W = DATA_W/8.
- COALESCE, 1: 1 enables merging into a matching entry; 0 makes every store allocate.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enq_valid  in  1  store request from the cache.
- enq_addr  in  ADDR_W  store byte address.
- enq_data  in  DATA_W  store data, lane-aligned.
- enq_be  in  BE_W  byte enables.
- enq_ready  out  1  store accepted this cycle.
- stall_pipeline  out  1  enq_valid && !enq_ready.
- lookup_valid  in  1  load probe.
- lookup_addr  in  ADDR_W  load byte address.
- lookup_req_be  in  BE_W  bytes the load needs.
- lookup_hit  out  1  at least one requested byte is buffered.
- lookup_full  out  1  every requested byte is buffered.
- lookup_data  out  DATA_W  forwarded bytes; 0 in uncovered lanes.
- lookup_be  out  BE_W  lanes supplied by the buffer, masked by lookup_req_be.
- drain_valid  out  1  head entry is presented.
- drain_addr  out  ADDR_W  head word address (low log2(BE_W) bits = 0).
- drain_data  out  DATA_W  head data.
- drain_be  out  BE_W  head byte enables.
- drain_ready  in  1  consumer accepts the head.
- count  out  log2(DEPTH)+1  number of occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Storage and pointers:
  - Circular array of DEPTH entries {word_addr, data, be}.
  - head/tail pointers log2(DEPTH) wide, wrap DEPTH-1 -> 0.
  - count register runs 0..DEPTH.
  - Word match compares addr[ADDR_W-1:log2(BE_W)].
- Reset (synchronous): head=tail=count=0 and all entry be cleared. Outputs then read drain_valid=0, empty=1, full=0, enq_ready=1, lookup_hit=0, lookup_full=0, lookup_be=0, lookup_data=0.
- Coalesce target: youngest occupied entry whose word address matches enq_addr.
  - The head entry is excluded whenever drain_valid=1, regardless of drain_ready.
  - Consequences: drain_* stays stable until accepted, and enq_ready has no combinational path from drain_ready.
- Coalesce hit (COALESCE=1, target exists): for each lane with enq_be set, overwrite the entry's data byte and set its be bit. tail and count are unchanged.
- Otherwise a store allocates at tail with be=enq_be and tail advances.
- enq_ready = coalesce_hit || !full. A full buffer with a pending pop still deasserts enq_ready, so there is no drain-to-enq bypass.
- Drain: drain_valid = !empty. Pop on drain_valid && drain_ready: head advances and the entry's be is cleared.
- Simultaneous allocate and pop: count is unchanged, and both pointers advance.
- Simultaneous coalesce and pop: count decrements.
- Forwarding (combinational, registered contents only):
  - An enqueue in the same cycle is NOT visible to lookup.
  - Per lane: take the byte from the youngest occupied entry that word-matches and has that be bit set. Search order runs from tail-1 back to head.
  - A lane with no covering entry returns data 0 and be 0.
  - lookup_be = covered lanes & lookup_req_be.
  - lookup_hit = lookup_valid && |lookup_be.
  - lookup_full = lookup_valid && (lookup_be == lookup_req_be) && |lookup_req_be.
  - lookup_valid=0 forces lookup_hit, lookup_full, lookup_be and lookup_data to 0.
- Boundary conditions:
  - enq_valid with enq_be=0: accepted; no entry is allocated or modified.
  - COALESCE=0: a duplicate word address allocates a new entry, and forwarding still picks the youngest.
  - Wrap-around must not corrupt youngest-first ordering.
- Latency:
  - An accepted store is visible to lookup and drain from the next cycle.
  - Minimum residency is 1 cycle.

Test Plan:
- Reset, then enq 0x100/0xAABBCCDD/be=1111 -> next cycle drain_valid=1, drain_addr=0x100, drain_data=0xAABBCCDD, count=1.
- Hold drain_ready=0. Enq 0x200 be=1111, then enq 0x202 data=0x00EE0000 be=0100 -> second store coalesces into entry 0x200 with byte2=0xEE and count stays 2. Then enq 0x100 -> allocates a third entry because the head is excluded from coalescing; count=3.
- Fill DEPTH=4 distinct words with drain_ready=0 -> full=1. A 5th distinct enq gives enq_ready=0 and stall_pipeline=1. An enq matching a non-head entry gives enq_ready=1.
- COALESCE=0: enq 0x300 data 0x11111111, then 0x300 data 0x22222222 be=0011. Lookup 0x300 req_be=1111 -> lookup_data=0x11112222, lookup_full=1, count=2.
- Lookup 0x400 req_be=0001 with the buffer holding 0x400 be=0010 -> lookup_hit=0, lookup_be=0. Enq 0x400 be=0001 in the same cycle -> the lookup still misses; the next cycle lookup_hit=1.
- Run 10 stores and 10 pops with drain_ready toggling every cycle, then assert reset mid-run -> pop order equals enqueue order across pointer wrap, and one cycle after reset empty=1 and drain_valid=0.

Source files
------------

// File: rtl/coalescing_store_buffer_if.sv
// Bus bundle for the coalescing store buffer.
//   enq_*    : store requests from the data-cache store-hit path (valid/ready).
//   lookup_* : combinational load probe from MEM and the forwarding result.
//   drain_*  : head-entry drain toward the cache/backing-memory write port.
// The master modport is the environment (cache pipeline plus write-port consumer).
// The slave modport is the buffer itself.
interface coalescing_store_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              enq_valid;
  logic [ADDR_W-1:0] enq_addr;
  logic [DATA_W-1:0] enq_data;
  logic [BE_W-1:0]   enq_be;
  logic              enq_ready;
  logic              stall_pipeline;

  logic              lookup_valid;
  logic [ADDR_W-1:0] lookup_addr;
  logic [BE_W-1:0]   lookup_req_be;
  logic              lookup_hit;
  logic              lookup_full;
  logic [DATA_W-1:0] lookup_data;
  logic [BE_W-1:0]   lookup_be;

  logic              drain_valid;
  logic [ADDR_W-1:0] drain_addr;
  logic [DATA_W-1:0] drain_data;
  logic [BE_W-1:0]   drain_be;
  logic              drain_ready;

  modport master (
    output enq_valid, enq_addr, enq_data, enq_be,
    input  enq_ready, stall_pipeline,
    output lookup_valid, lookup_addr, lookup_req_be,
    input  lookup_hit, lookup_full, lookup_data, lookup_be,
    input  drain_valid, drain_addr, drain_data, drain_be,
    output drain_ready
  );

  modport slave (
    input  enq_valid, enq_addr, enq_data, enq_be,
    output enq_ready, stall_pipeline,
    input  lookup_valid, lookup_addr, lookup_req_be,
    output lookup_hit, lookup_full, lookup_data, lookup_be,
    output drain_valid, drain_addr, drain_data, drain_be,
    input  drain_ready
  );
endinterface

// File: rtl/coalescing_store_buffer.sv
// Coalescing store buffer: a DEPTH-entry circular FIFO of {word address, data,
// byte enables} between the cache store-hit path and the memory write port.
// Stores merge byte-wise into the youngest matching non-head entry (COALESCE=1)
// or allocate at the tail. Loads probe all occupied entries combinationally
// and receive, per byte lane, the byte from the youngest covering entry.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   sb         : enq / lookup / drain bus (slave side)
//   count      : occupied entries, 0..DEPTH
//   empty/full : count==0 / count==DEPTH
module coalescing_store_buffer #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int COALESCE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  coalescing_store_buffer_if.slave   sb,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(BE_W);
  localparam int WA_W  = ADDR_W - OFF_W;

  logic [WA_W-1:0]   ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [BE_W-1:0]   ent_be   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Entries viewed by age: age 0 is the head (oldest), age count-1 the youngest.
  logic [PTR_W-1:0] age_idx [DEPTH];
  logic             age_occ [DEPTH];

  logic [WA_W-1:0]  enq_waddr;
  logic [WA_W-1:0]  look_waddr;
  logic             coal_found;
  logic [PTR_W-1:0] coal_idx;
  logic             coal_hit;
  logic             enq_fire;
  logic             do_coal;
  logic             do_alloc;
  logic             pop;

  logic [BE_W-1:0]   fwd_cov;
  logic [DATA_W-1:0] fwd_data;
  logic [BE_W-1:0]   look_be;

  assign enq_waddr  = WA_W'(sb.enq_addr >> OFF_W);
  assign look_waddr = WA_W'(sb.lookup_addr >> OFF_W);

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_idx[k] = head + PTR_W'(k);
      age_occ[k] = (CNT_W'(k) < count);
    end
  end

  // Coalesce target search starts at age 1: the head is excluded whenever
  // it is occupied (i.e. presented on drain), so drain_* never changes under
  // the consumer and enq_ready never depends on drain_ready.
  always_comb begin
    coal_found = 1'b0;
    coal_idx   = head;
    for (int k = 1; k < DEPTH; k++) begin
      if (age_occ[k] && (ent_addr[age_idx[k]] == enq_waddr)) begin
        coal_found = 1'b1;
        coal_idx   = age_idx[k];
      end
    end
  end

  assign coal_hit          = (COALESCE != 0) && coal_found;
  assign empty             = (count == '0);
  assign full              = (count == CNT_W'(DEPTH));
  assign sb.enq_ready      = coal_hit || !full;
  assign sb.stall_pipeline = sb.enq_valid && !sb.enq_ready;

  // A store with no byte enables is accepted but leaves the buffer untouched.
  assign enq_fire = sb.enq_valid && sb.enq_ready;
  assign do_coal  = enq_fire && (|sb.enq_be) && coal_hit;
  assign do_alloc = enq_fire && (|sb.enq_be) && !coal_hit;

  assign sb.drain_valid = !empty;
  assign sb.drain_addr  = ADDR_W'(ent_addr[head]) << OFF_W;
  assign sb.drain_data  = ent_data[head];
  assign sb.drain_be    = ent_be[head];
  assign pop            = sb.drain_valid && sb.drain_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent_be[i] <= '0;
    end else begin
      // Coalesce never targets the head, and allocation only happens when
      // not full, so these writes never land on the same entry.
      if (pop) begin
        ent_be[head] <= '0;
        head         <= head + PTR_W'(1);
      end
      if (do_coal) begin
        for (int b = 0; b < BE_W; b++) begin
          if (sb.enq_be[b]) begin
            ent_data[coal_idx][8*b +: 8] <= sb.enq_data[8*b +: 8];
            ent_be[coal_idx][b]          <= 1'b1;
          end
        end
      end
      if (do_alloc) begin
        ent_addr[tail] <= enq_waddr;
        ent_data[tail] <= sb.enq_data;
        ent_be[tail]   <= sb.enq_be;
        tail           <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(do_alloc) - CNT_W'(pop);
    end
  end

  // Forwarding walks oldest to youngest so younger entries overwrite older
  // ones lane by lane; only registered contents are visible.
  always_comb begin
    fwd_cov  = '0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_occ[k] && (ent_addr[age_idx[k]] == look_waddr)) begin
        for (int b = 0; b < BE_W; b++) begin
          if (ent_be[age_idx[k]][b]) begin
            fwd_cov[b]          = 1'b1;
            fwd_data[8*b +: 8]  = ent_data[age_idx[k]][8*b +: 8];
          end
        end
      end
    end
  end

  assign look_be = sb.lookup_valid ? (fwd_cov & sb.lookup_req_be) : '0;

  always_comb begin
    sb.lookup_data = '0;
    for (int b = 0; b < BE_W; b++) begin
      if (look_be[b]) sb.lookup_data[8*b +: 8] = fwd_data[8*b +: 8];
    end
  end

  assign sb.lookup_be   = look_be;
  assign sb.lookup_hit  = sb.lookup_valid && (|look_be);
  assign sb.lookup_full = sb.lookup_valid && (look_be == sb.lookup_req_be) && (|sb.lookup_req_be);
endmodule
